// File: rtl/mesm6_mem_pkg.sv
// Shared widths, FSM state encoding and the captured-request payload for the
// MESM-6 memory responder.
package mesm6_mem_pkg;

   localparam int unsigned ADDR_W = 15;
   localparam int unsigned WORD_W = 48;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [1:0] {MS_IDLE, MS_DACC, MS_IACC, MS_DONE} mem_state_t;

   // Request set latched in IDLE; everything served afterwards comes from here.
   typedef struct packed {
      logic              pend_d;
      logic              pend_i;
      logic              wr;
      logic [ADDR_W-1:0] iaddr;
      logic [ADDR_W-1:0] daddr;
      logic [WORD_W-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/mesm6_sram.sv
// Single-port synchronous word store, 2^15 x 48, read-first.
// Ports: clk; we (write enable); addr (word address); wdata (write word);
//        rdata (word at the address presented on the previous clock).
module mesm6_sram
   import mesm6_mem_pkg::*;
#(
   parameter string INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin : store
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/mesm6_memctl.sv
// MESM-6 memory responder: slave end of ibus (fetch) and dbus (read/write).
// Data is served before instruction; both dones pulse together in DONE.
// Ports: clk, reset (sync, active-high);
//        ibus_fetch/ibus_addr in, ibus_input/ibus_done out;
//        dbus_read/dbus_write/dbus_addr/dbus_output in, dbus_input/dbus_done out.
module mesm6_memctl
   import mesm6_mem_pkg::*;
#(
   parameter int unsigned WAIT_STATES = 0,
   parameter string       INIT_FILE   = ""
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ibus_fetch,
   input  logic [ADDR_W-1:0] ibus_addr,
   output logic [WORD_W-1:0] ibus_input,
   output logic              ibus_done,
   input  logic              dbus_read,
   input  logic              dbus_write,
   input  logic [ADDR_W-1:0] dbus_addr,
   input  logic [WORD_W-1:0] dbus_output,
   output logic [WORD_W-1:0] dbus_input,
   output logic              dbus_done
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_STATES);

   mem_state_t        state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   mem_req_t          req;
   logic              last_c;
   logic              sram_we;
   logic [ADDR_W-1:0] sram_addr;
   logic [WORD_W-1:0] rdata;
   logic [WORD_W-1:0] d_word_c, i_word_c, i_fwd_c;

   assign last_c = (cnt == LAST_CNT);

   // Next-state: data access first, then instruction access, then one DONE cycle.
   always_comb begin : next_state
      state_nxt = state;
      case (state)
         MS_IDLE: begin
            if (dbus_read | dbus_write) state_nxt = MS_DACC;
            else if (ibus_fetch)        state_nxt = MS_IACC;
         end
         MS_DACC: if (last_c) state_nxt = req.pend_i ? MS_IACC : MS_DONE;
         MS_IACC: if (last_c) state_nxt = MS_DONE;
         default: state_nxt = MS_IDLE;
      endcase
   end

   // Store port steering. The address is always presented one clock ahead of
   // when its word is needed. A write occupies the port in the last DACC cycle,
   // so a concurrent fetch is read earlier (IDLE / non-final DACC cycles).
   always_comb begin : sram_ctrl
      sram_we   = 1'b0;
      sram_addr = req.daddr;
      case (state)
         MS_IDLE: begin
            sram_addr = (ibus_fetch && (dbus_write || !dbus_read)) ? ibus_addr : dbus_addr;
         end
         MS_DACC: begin
            if (req.wr) begin
               sram_addr = last_c ? req.daddr : req.iaddr;
               sram_we   = last_c && (req.daddr != '0) && !reset;
            end else begin
               sram_addr = (last_c && req.pend_i) ? req.iaddr : req.daddr;
            end
         end
         MS_IACC: sram_addr = req.iaddr;
         default: sram_addr = req.daddr;
      endcase
   end

   // Result words with address-0 masking; a fetch of the word just written
   // sees the new value because data is served first.
   always_comb begin : result_words
      d_word_c = (req.daddr == '0) ? '0 : (req.wr ? req.wdata : rdata);
      i_word_c = (req.iaddr == '0) ? '0 : rdata;
      i_fwd_c  = (req.iaddr == '0) ? '0 :
                 ((req.iaddr == req.daddr) ? req.wdata : rdata);
   end

   always_ff @(posedge clk) begin : regs
      if (reset) begin
         state      <= MS_IDLE;
         cnt        <= '0;
         req        <= '0;
         ibus_done  <= 1'b0;
         dbus_done  <= 1'b0;
         ibus_input <= '0;
         dbus_input <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= ((state_nxt == state) && (state == MS_DACC || state == MS_IACC))
                  ? cnt + CNT_W'(1) : '0;
         if (state == MS_IDLE) begin
            req <= '{pend_d: dbus_read | dbus_write,
                     pend_i: ibus_fetch,
                     wr:     dbus_write,
                     iaddr:  ibus_addr,
                     daddr:  dbus_addr,
                     wdata:  dbus_output};
         end
         ibus_done <= (state_nxt == MS_DONE) && req.pend_i;
         dbus_done <= (state_nxt == MS_DONE) && req.pend_d;
         if (state == MS_DACC && last_c) begin
            dbus_input <= d_word_c;
            if (req.wr && req.pend_i) ibus_input <= i_fwd_c;
         end
         if (state == MS_IACC && last_c && !req.wr) ibus_input <= i_word_c;
      end
   end

   mesm6_sram #(.INIT_FILE(INIT_FILE)) u_sram (
      .clk   (clk),
      .we    (sram_we),
      .addr  (sram_addr),
      .wdata (req.wdata),
      .rdata (rdata)
   );

endmodule

// File: tb/tb_mesm6_memctl.sv
// Self-checking bench for mesm6_memctl: two instances (WAIT_STATES 0 and 3)
// checked against a word-array reference model and latency formulas.
module tb_mesm6_memctl;
   import mesm6_mem_pkg::*;

   localparam int NI = 2;

   logic        clk = 1'b0;
   logic        reset       [NI];
   logic        ibus_fetch  [NI];
   logic [14:0] ibus_addr   [NI];
   logic [47:0] ibus_input  [NI];
   logic        ibus_done   [NI];
   logic        dbus_read   [NI];
   logic        dbus_write  [NI];
   logic [14:0] dbus_addr   [NI];
   logic [47:0] dbus_output [NI];
   logic [47:0] dbus_input  [NI];
   logic        dbus_done   [NI];

   int n_checks = 0;
   int n_errors = 0;

   logic [47:0] mem_m  [NI][128];
   logic [47:0] last_i [NI];
   logic [47:0] last_d [NI];

   always #5 clk = ~clk;

   mesm6_memctl #(.WAIT_STATES(0)) u_dut0 (
      .clk(clk), .reset(reset[0]),
      .ibus_fetch(ibus_fetch[0]), .ibus_addr(ibus_addr[0]),
      .ibus_input(ibus_input[0]), .ibus_done(ibus_done[0]),
      .dbus_read(dbus_read[0]), .dbus_write(dbus_write[0]),
      .dbus_addr(dbus_addr[0]), .dbus_output(dbus_output[0]),
      .dbus_input(dbus_input[0]), .dbus_done(dbus_done[0]));

   mesm6_memctl #(.WAIT_STATES(3)) u_dut3 (
      .clk(clk), .reset(reset[1]),
      .ibus_fetch(ibus_fetch[1]), .ibus_addr(ibus_addr[1]),
      .ibus_input(ibus_input[1]), .ibus_done(ibus_done[1]),
      .dbus_read(dbus_read[1]), .dbus_write(dbus_write[1]),
      .dbus_addr(dbus_addr[1]), .dbus_output(dbus_output[1]),
      .dbus_input(dbus_input[1]), .dbus_done(dbus_done[1]));

   function automatic int ws_of(int k);
      return (k == 0) ? 0 : 3;
   endfunction

   task automatic check(string tag, logic [47:0] got, logic [47:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drop(int k);
      ibus_fetch[k] = 1'b0;
      dbus_read[k]  = 1'b0;
      dbus_write[k] = 1'b0;
   endtask

   // One transaction issued in the current (IDLE) cycle; returns in the next IDLE cycle.
   task automatic txn(int k, bit f, logic [14:0] ia, bit r, bit w,
                      logic [14:0] da, logic [47:0] wd);
      int          lat;
      bit          pd;
      logic [47:0] exp_d, exp_i;
      pd    = r | w;
      exp_d = last_d[k];
      exp_i = last_i[k];
      if (pd) begin
         exp_d = (da == 0) ? 48'h0 : (w ? wd : mem_m[k][da]);
         if (w && da != 0) mem_m[k][da] = wd;
      end
      if (f) exp_i = (ia == 0) ? 48'h0 : mem_m[k][ia];
      if (pd && f)      lat = 3 + 2 * ws_of(k);
      else if (pd || f) lat = 2 + ws_of(k);
      else              lat = 0;

      ibus_fetch[k]  = f;
      ibus_addr[k]   = ia;
      dbus_read[k]   = r;
      dbus_write[k]  = w;
      dbus_addr[k]   = da;
      dbus_output[k] = wd;

      for (int c = 1; c <= lat; c++) begin
         @(negedge clk);
         check($sformatf("ibus_done k%0d c%0d", k, c), 48'(ibus_done[k]), 48'(f && c == lat));
         check($sformatf("dbus_done k%0d c%0d", k, c), 48'(dbus_done[k]), 48'(pd && c == lat));
         if (c == lat) begin
            check($sformatf("ibus_input k%0d a%0d", k, ia), ibus_input[k], exp_i);
            check($sformatf("dbus_input k%0d a%0d", k, da), dbus_input[k], exp_d);
            drop(k);
         end else begin
            ibus_addr[k]   = 15'($urandom);
            dbus_addr[k]   = 15'($urandom);
            dbus_output[k] = {16'($urandom), $urandom};
         end
      end
      last_d[k] = exp_d;
      last_i[k] = exp_i;
      drop(k);
      @(negedge clk);
      check($sformatf("idle ibus_done k%0d", k), 48'(ibus_done[k]), 48'h0);
      check($sformatf("idle dbus_done k%0d", k), 48'(dbus_done[k]), 48'h0);
      check($sformatf("hold ibus_input k%0d", k), ibus_input[k], exp_i);
      check($sformatf("hold dbus_input k%0d", k), dbus_input[k], exp_d);
   endtask

   task automatic wr(int k, logic [14:0] a, logic [47:0] d);
      txn(k, 1'b0, 15'd0, 1'b0, 1'b1, a, d);
   endtask

   initial begin
      for (int k = 0; k < NI; k++) begin
         reset[k] = 1'b1;
         drop(k);
         ibus_addr[k]   = '0;
         dbus_addr[k]   = '0;
         dbus_output[k] = '0;
         last_i[k]      = '0;
         last_d[k]      = '0;
         for (int a = 0; a < 128; a++) mem_m[k][a] = '0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         reset[k] = 1'b0;
         check($sformatf("rst ibus_done k%0d", k), 48'(ibus_done[k]), 48'h0);
         check($sformatf("rst dbus_done k%0d", k), 48'(dbus_done[k]), 48'h0);
         check($sformatf("rst ibus_input k%0d", k), ibus_input[k], 48'h0);
         check($sformatf("rst dbus_input k%0d", k), dbus_input[k], 48'h0);
      end
      @(negedge clk);

      // Preload every address the random phase touches.
      for (int k = 0; k < NI; k++)
         for (int a = 1; a < 16; a++) wr(k, 15'(a), {16'($urandom), $urandom});

      // Fetch-only.
      wr(0, 15'd5, 48'o1234567012345670);
      txn(0, 1'b1, 15'd5, 1'b0, 1'b0, 15'd0, 48'h0);

      // Write then read with wait states.
      wr(1, 15'd100, 48'hA5A5_0000_FFFF);
      txn(1, 1'b0, 15'd0, 1'b1, 1'b0, 15'd100, 48'h0);

      // Concurrent read + fetch.
      for (int k = 0; k < NI; k++) begin
         wr(k, 15'd7, 48'd1);
         wr(k, 15'd8, 48'd2);
         txn(k, 1'b1, 15'd8, 1'b1, 1'b0, 15'd7, 48'h0);
      end

      // Address 0 is a hard zero.
      for (int k = 0; k < NI; k++) begin
         wr(k, 15'd0, 48'hFFFF_FFFF_FFFF);
         txn(k, 1'b1, 15'd0, 1'b1, 1'b0, 15'd0, 48'h0);
      end

      // Write + fetch of the same word, and read+write together.
      for (int k = 0; k < NI; k++) begin
         txn(k, 1'b1, 15'd3, 1'b0, 1'b1, 15'd3, 48'h1111_2222_3333);
         txn(k, 1'b1, 15'd4, 1'b1, 1'b1, 15'd6, 48'h4444_5555_6666);
      end

      // Reset mid-write: write to 9 accepted, reset two cycles later.
      wr(1, 15'd9, 48'd3);
      dbus_write[1]  = 1'b1;
      dbus_addr[1]   = 15'd9;
      dbus_output[1] = 48'h7777_7777_7777;
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         check($sformatf("mid-write dbus_done c%0d", c), 48'(dbus_done[1]), 48'h0);
      end
      reset[1] = 1'b1;
      drop(1);
      @(negedge clk);
      reset[1] = 1'b0;
      check("post-reset dbus_done", 48'(dbus_done[1]), 48'h0);
      check("post-reset dbus_input", dbus_input[1], 48'h0);
      check("post-reset ibus_input", ibus_input[1], 48'h0);
      last_d[1] = '0;
      last_i[1] = '0;
      @(negedge clk);
      check("post-reset idle dbus_done", 48'(dbus_done[1]), 48'h0);
      txn(1, 1'b0, 15'd0, 1'b1, 1'b0, 15'd9, 48'h0);

      // Held read request: one done per 3+WS cycles, never adjacent.
      begin
         int          first, period;
         bit          prev;
         logic [47:0] exp;
         first  = 2 + ws_of(0);
         period = 3 + ws_of(0);
         exp    = mem_m[0][11];
         prev   = 1'b0;
         dbus_read[0] = 1'b1;
         dbus_addr[0] = 15'd11;
         for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            check($sformatf("held dbus_done c%0d", c), 48'(dbus_done[0]),
                  48'(c >= first && (c - first) % period == 0));
            check($sformatf("held adjacent c%0d", c), 48'(prev && dbus_done[0]), 48'h0);
            if (dbus_done[0]) check($sformatf("held dbus_input c%0d", c), dbus_input[0], exp);
            prev = dbus_done[0];
         end
         drop(0);
         repeat (period) @(negedge clk);
         last_d[0] = exp;
      end

      // Randomized traffic against the model.
      for (int n = 0; n < 80; n++) begin
         int          k;
         bit          f, r, w;
         k = int'($urandom_range(0, 1));
         f = 1'($urandom);
         r = 1'($urandom);
         w = 1'($urandom);
         if (!(f || r || w)) f = 1'b1;
         txn(k, f, 15'($urandom_range(0, 15)), r, w,
             15'($urandom_range(0, 15)), {16'($urandom), $urandom});
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
